// File: rtl/dice_tally.sv
// Watches button/throw from the dice, latches each accepted roll's final face and keeps saturating per-face and total counts.
// Results/pulses appear one cycle after button falls; rd_count has 1-cycle latency, no backpressure.
module dice_tally #(
    parameter int COUNT_W  = 8,
    parameter int MIN_ROLL = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               button,
    input  logic [2:0]         throw,
    input  logic [2:0]         rd_face,
    output logic [2:0]         result,
    output logic               result_valid,
    output logic               short_roll,
    output logic               bad_throw,
    output logic [COUNT_W-1:0] rd_count,
    output logic [COUNT_W-1:0] total
);

    localparam int HW = $clog2(MIN_ROLL + 1);
    localparam logic [HW-1:0] HOLD_MAX = HW'(MIN_ROLL);
    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] ROLL = 1'b1;

    logic [0:0]         state;
    logic [HW-1:0]      hold_cnt;
    logic [COUNT_W-1:0] face_cnt [6];
    logic               throw_legal;
    logic               rd_legal;
    logic [2:0]         throw_idx;
    logic [2:0]         rd_idx;

    assign throw_legal = (throw >= 3'd1) && (throw <= 3'd6);
    assign rd_legal    = (rd_face >= 3'd1) && (rd_face <= 3'd6);
    assign throw_idx   = throw - 3'd1;
    assign rd_idx      = rd_face - 3'd1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            hold_cnt     <= '0;
            result       <= '0;
            result_valid <= 1'b0;
            short_roll   <= 1'b0;
            bad_throw    <= 1'b0;
            rd_count     <= '0;
            total        <= '0;
            for (int i = 0; i < 6; i++) begin
                face_cnt[i] <= '0;
            end
        end else begin
            result_valid <= 1'b0;
            short_roll   <= 1'b0;
            // Reads the pre-update counter value; an increment on this edge shows up next cycle.
            rd_count     <= rd_legal ? face_cnt[rd_idx] : '0;

            case (state)
                IDLE: begin
                    if (button) begin
                        state    <= ROLL;
                        hold_cnt <= HW'(1);
                    end
                end
                default: begin
                    if (button) begin
                        if (hold_cnt < HOLD_MAX) begin
                            hold_cnt <= hold_cnt + HW'(1);
                        end
                    end else begin
                        state    <= IDLE;
                        hold_cnt <= '0;
                        // throw on the release edge is final: the dice freezes on this same edge.
                        if (hold_cnt >= HOLD_MAX) begin
                            result       <= throw;
                            result_valid <= 1'b1;
                            if (throw_legal) begin
                                if (face_cnt[throw_idx] != '1) begin
                                    face_cnt[throw_idx] <= face_cnt[throw_idx] + 1'b1;
                                end
                                if (total != '1) begin
                                    total <= total + 1'b1;
                                end
                            end else begin
                                bad_throw <= 1'b1;
                            end
                        end else begin
                            short_roll <= 1'b1;
                        end
                    end
                end
            endcase
        end
    end

endmodule
